commit_trace_buffer: RTL

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO between a CPU's retire stage and a host/difftest consumer.
// Tracks commit count, idle timeout, dropped commits and ebreak halt as sticky status.
module commit_trace_buffer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_i_valid,
  input  logic [31:0]              commit_i_instr,
  input  logic [63:0]              commit_i_pc,
  input  logic [63:0]              commit_i_pre_pc,
  input  logic                     trace_i_ready,
  input  logic                     trace_i_clear,
  output logic                     trace_o_valid,
  output logic [31:0]              trace_o_instr,
  output logic [63:0]              trace_o_pc,
  output logic [63:0]              trace_o_pre_pc,
  output logic [31:0]              trace_o_seq,
  output logic [$clog2(DEPTH):0]   trace_o_count,
  output logic [63:0]              trace_o_commit_cnt,
  output logic                     trace_o_overflow,
  output logic                     trace_o_timeout,
  output logic                     trace_o_halt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DepthCnt   = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0] TimeoutCnt = IW'(TIMEOUT);
  localparam logic [31:0]   Ebreak     = 32'h00100073;

  logic [31:0] instr_mem  [DEPTH];
  logic [63:0] pc_mem     [DEPTH];
  logic [63:0] pre_pc_mem [DEPTH];
  logic [31:0] seq_mem    [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [63:0]   commit_cnt_q;
  logic [IW-1:0] idle_q;
  logic          overflow_q, timeout_q, halt_q;

  logic pop, push, drop, idle_tick;

  always_comb begin
    pop  = (count_q != '0) && trace_i_ready;
    push = commit_i_valid && !halt_q && ((count_q < DepthCnt) || pop);
    // Commits arriving while halted are ignored, not counted as drops.
    drop = commit_i_valid && !halt_q && !push;
    idle_tick = !halt_q && !commit_i_valid && (idle_q < TimeoutCnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q]  <= commit_i_instr;
      pc_mem[wr_ptr_q]     <= commit_i_pc;
      pre_pc_mem[wr_ptr_q] <= commit_i_pre_pc;
      seq_mem[wr_ptr_q]    <= commit_cnt_q[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_cnt_q <= '0;
      idle_q       <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      halt_q       <= 1'b0;
    end else if (trace_i_clear) begin
      commit_cnt_q <= '0;
      idle_q       <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      if (push) commit_cnt_q <= commit_cnt_q + 64'd1;
      if (drop) overflow_q <= 1'b1;
      if (push && (commit_i_instr == Ebreak)) halt_q <= 1'b1;
      if (!halt_q) begin
        if (commit_i_valid) idle_q <= '0;
        else if (idle_tick) idle_q <= idle_q + 1'b1;
      end
      if (idle_tick && (idle_q == TimeoutCnt - 1'b1)) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    trace_o_valid      = (count_q != '0);
    trace_o_instr      = trace_o_valid ? instr_mem[rd_ptr_q]  : '0;
    trace_o_pc         = trace_o_valid ? pc_mem[rd_ptr_q]     : '0;
    trace_o_pre_pc     = trace_o_valid ? pre_pc_mem[rd_ptr_q] : '0;
    trace_o_seq        = trace_o_valid ? seq_mem[rd_ptr_q]    : '0;
    trace_o_count      = count_q;
    trace_o_commit_cnt = commit_cnt_q;
    trace_o_overflow   = overflow_q;
    trace_o_timeout    = timeout_q;
    trace_o_halt       = halt_q;
  end

endmodule
